// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, funct3 codes, stage encodings and the ALU helper
// shared by the riscv_core CPU and its memories.
package riscv_pkg;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;

    localparam logic [2:0] LW   = 3'b010;
    localparam logic [2:0] SW   = 3'b010;
    localparam logic [2:0] ADDI = 3'b000;

    localparam logic [4:0] S1 = 5'b00001;
    localparam logic [4:0] S2 = 5'b00010;
    localparam logic [4:0] S3 = 5'b00100;
    localparam logic [4:0] S4 = 5'b01000;
    localparam logic [4:0] S5 = 5'b10000;

    // alt selects SUB for funct3=000 and arithmetic shift for funct3=101
    function automatic logic [31:0] alu(
        input logic [2:0]  f3,
        input logic        alt,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] r;
        case (f3)
            3'b000:  r = alt ? a - b : a + b;
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'b0, $signed(a) < $signed(b)};
            3'b011:  r = {31'b0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/riscv_mem.sv
// riscv_mem: array with synchronous write and combinational read.
// LANES consecutive entries form one access word, first entry most significant.
module riscv_mem
    import riscv_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1024,
    parameter int LANES = 1
) (
    input  logic                       clk,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_addr,
    input  logic [WIDTH*LANES-1:0]     i_wdata,
    output logic [WIDTH*LANES-1:0]     o_rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [0:DEPTH-1] = '{default: '0};

    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < LANES; i++) begin
            o_rdata[WIDTH*(LANES-1-i) +: WIDTH] = mem[i_addr + AW'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < LANES; i++) begin
                mem[i_addr + AW'(i)] <= i_wdata[WIDTH*(LANES-1-i) +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/riscv_core.sv
// riscv_core: 5-clock multi-cycle RV32I subset CPU with ROM, RAM and GPIO.
// Define RISCV_ALU_EN for full OP-IMM and OP; otherwise only ADDI executes.
module riscv_core
    import riscv_pkg::*;
#(
    parameter int          PROG_WORDS = 1024,
    parameter int          DATA_BYTES = 1024,
    parameter logic [31:0] GPIO_ADDR  = 32'h400
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] gpio
);
    localparam int PAW = $clog2(PROG_WORDS);
    localparam int DAW = $clog2(DATA_BYTES);

    logic [4:0]  stage  = S1;
    logic [31:0] pc     = '0;
    logic [6:0]  opcode = '0;
    logic [31:0] regs [0:31] = '{default: '0};
    logic [7:0]  r_gpio = '0;

    logic [31:7] r_instr  = '0;
    logic [31:0] r_rs1v   = '0;
    logic [31:0] r_rs2v   = '0;
    logic [31:0] r_imm    = '0;
    logic [31:0] r_res    = '0;
    logic [29:0] r_waddr  = '0;
    logic [31:0] r_npc    = '0;
    logic        r_wr_rd  = 1'b0;
    logic        r_wr_mem = 1'b0;
    logic        r_ld     = 1'b0;

    logic [4:0]  w_stage_nxt;
    logic [31:0] w_fetch;
    logic [31:0] w_imm;
    logic [31:0] w_sum;
    logic [31:0] w_link;
    logic [31:0] w_res;
    logic [31:0] w_npc;
    logic        w_wr_rd;
    logic        w_wr_mem;
    logic        w_ld;
    logic [2:0]  w_f3;
    logic [4:0]  w_rd;
    logic        w_gpio_hit;
    logic        w_ram_we;
    logic [31:0] w_ram_rdata;
    logic [31:0] w_wb;

    assign gpio = r_gpio;
    assign w_f3 = r_instr[14:12];
    assign w_rd = r_instr[11:7];

    riscv_mem #(.WIDTH(32), .DEPTH(PROG_WORDS), .LANES(1)) prog (
        .clk     (clk),
        .i_we    (1'b0),
        .i_addr  (pc[PAW-1:0]),
        .i_wdata (32'h0),
        .o_rdata (w_fetch)
    );

    assign w_gpio_hit = (r_waddr == GPIO_ADDR[31:2]);
    assign w_ram_we   = (stage == S4) && r_wr_mem && !w_gpio_hit && !reset;

    riscv_mem #(.WIDTH(8), .DEPTH(DATA_BYTES), .LANES(4)) memory (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  ({r_waddr[DAW-3:0], 2'b00}),
        .i_wdata (r_rs2v),
        .o_rdata (w_ram_rdata)
    );

    always_comb begin
        w_stage_nxt = S1;
        unique case (1'b1)
            stage[0]: w_stage_nxt = S2;
            stage[1]: w_stage_nxt = S3;
            stage[2]: w_stage_nxt = S4;
            stage[3]: w_stage_nxt = S5;
            default:  w_stage_nxt = S1;
        endcase
    end

    always_comb begin
        w_imm = {{20{r_instr[31]}}, r_instr[31:20]};
        case (opcode)
            LUI, AUIPC: w_imm = {r_instr[31:12], 12'h0};
            JAL: w_imm = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12],
                          r_instr[20], r_instr[30:21], 1'b0};
            STORE: w_imm = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
            default: ;
        endcase
    end

    assign w_sum  = r_rs1v + r_imm;
    assign w_link = (pc + 32'd1) << 2;

    always_comb begin
        w_res    = '0;
        w_npc    = pc + 32'd1;
        w_wr_rd  = 1'b0;
        w_wr_mem = 1'b0;
        w_ld     = 1'b0;
        case (opcode)
            LUI: begin
                w_res   = r_imm;
                w_wr_rd = 1'b1;
            end
            AUIPC: begin
                w_res   = (pc << 2) + r_imm;
                w_wr_rd = 1'b1;
            end
            JAL: begin
                w_res   = w_link;
                w_npc   = pc + 32'($signed(r_imm) >>> 2);
                w_wr_rd = 1'b1;
            end
            JALR: begin
                w_res   = w_link;
                w_npc   = (w_sum & ~32'h1) >> 2;
                w_wr_rd = 1'b1;
            end
            LOAD: begin
                w_ld    = (w_f3 == LW);
                w_wr_rd = (w_f3 == LW);
            end
            STORE: w_wr_mem = (w_f3 == SW);
`ifdef RISCV_ALU_EN
            OP_IMM: begin
                w_res   = alu(w_f3, (w_f3 == 3'b101) && r_instr[30],
                              r_rs1v, r_imm);
                w_wr_rd = 1'b1;
            end
            OP: begin
                w_res   = alu(w_f3, r_instr[30], r_rs1v, r_rs2v);
                w_wr_rd = 1'b1;
            end
`else
            OP_IMM: begin
                w_res   = w_sum;
                w_wr_rd = (w_f3 == ADDI);
            end
`endif
            default: ;
        endcase
    end

    assign w_wb = !r_ld ? r_res :
                  w_gpio_hit ? {24'h0, r_gpio} : w_ram_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage  <= S1;
            pc     <= '0;
            opcode <= '0;
            r_gpio <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            stage <= w_stage_nxt;
            unique case (1'b1)
                stage[0]: begin
                    r_instr <= w_fetch[31:7];
                    opcode  <= w_fetch[6:0];
                end
                stage[1]: begin
                    r_rs1v <= regs[r_instr[19:15]];
                    r_rs2v <= regs[r_instr[24:20]];
                    r_imm  <= w_imm;
                end
                stage[2]: begin
                    r_res    <= w_res;
                    r_waddr  <= w_sum[31:2];
                    r_npc    <= w_npc;
                    r_wr_rd  <= w_wr_rd;
                    r_wr_mem <= w_wr_mem;
                    r_ld     <= w_ld;
                end
                stage[3]: begin
                    pc <= r_npc;
                    if (r_wr_rd && w_rd != 5'd0) regs[w_rd] <= w_wb;
                    if (r_wr_mem && w_gpio_hit) r_gpio <= r_rs2v[7:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_core.sv
// tb_riscv_core: directed vectors plus hand sequences for reset,
// load/store, jalr and GPIO behaviour of riscv_core.
module tb_riscv_core;
    import riscv_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] gpio;

    int n_run  = 0;
    int n_fail = 0;

    riscv_core dut (
        .clk   (clk),
        .reset (reset),
        .gpio  (gpio)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ncyc;
        logic [4:0]  stg;
        logic [31:0] pcv;
        int          ridx;
        logic [31:0] rval;
        int          op;
        string       nm;
    } vec_t;

    vec_t vecs [7];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ram_word0();
        return {dut.memory.mem[0], dut.memory.mem[1],
                dut.memory.mem[2], dut.memory.mem[3]};
    endfunction

    initial begin
        vecs[0] = '{3,   S5, 1, 1, 32'h0001F000, -1, "lui_x1"};
        vecs[1] = '{5,   S5, 2, 2, 32'h000F1000, -1, "lui_x2"};
        vecs[2] = '{5,   S5, 3, 3, 32'h0,        -1, "x3_pre_lw"};
        vecs[3] = '{5,   S5, 4, 3, 32'h0001F000, -1, "lw_x3"};
        vecs[4] = '{0,   S5, 31, 0, 32'h0,        0, "nop_end"};
        vecs[5] = '{5,   S5, 0, 0, 32'h0,  int'(JALR), "jalr_x0"};
        vecs[6] = '{160, S5, 2, 5, 32'd128, int'(JALR), "jalr_x5"};

        #1;
        dut.prog.mem[0]  = 32'h0001F0B7;
        dut.prog.mem[1]  = 32'h000F1137;
        dut.prog.mem[2]  = 32'h00102023;
        dut.prog.mem[3]  = 32'h00002183;
        dut.prog.mem[31] = 32'h00000067;
        #1;
        chk("pwr_stage", 32'(dut.stage), 32'(S1));
        chk("pwr_pc", dut.pc, 32'h0);
        chk("pwr_gpio", 32'(gpio), 32'h0);

        tick(1);
        chk("c1_stage", 32'(dut.stage), 32'(S2));
        chk("c1_opcode", 32'(dut.opcode), 32'(LUI));

        for (int i = 0; i < 7; i++) begin
            tick(vecs[i].ncyc);
            chk({vecs[i].nm, "_stage"}, 32'(dut.stage), 32'(vecs[i].stg));
            chk({vecs[i].nm, "_pc"}, dut.pc, vecs[i].pcv);
            chk({vecs[i].nm, "_reg"}, dut.regs[vecs[i].ridx], vecs[i].rval);
            if (vecs[i].op >= 0)
                chk({vecs[i].nm, "_op"}, 32'(dut.opcode), 32'(vecs[i].op));
            if (i == 2)
                chk("sw_ram", ram_word0(), 32'h0001F000);
            if (i == 3) begin
                for (int p = 4; p <= 30; p++) begin
                    tick(5);
                    chk("nop_pc", dut.pc, 32'(p + 1));
                    chk("nop_stage", 32'(dut.stage), 32'(S5));
                end
                chk("nop_x3_kept", dut.regs[3], 32'h0001F000);
            end
            if (i == 5)
                dut.prog.mem[31] = 32'h008002E7;
        end

        reset = 1'b1;
        dut.prog.mem[0] = 32'h05500213;
        dut.prog.mem[1] = 32'h40402023;
        dut.prog.mem[2] = 32'h00402023;
        tick(1);
        chk("rst_stage", 32'(dut.stage), 32'(S1));
        chk("rst_pc", dut.pc, 32'h0);
        chk("rst_x5", dut.regs[5], 32'h0);
        chk("rst_ram_kept", ram_word0(), 32'h0001F000);
        reset = 1'b0;

        tick(2);
        chk("s3_stage", 32'(dut.stage), 32'(S3));
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("abort_stage", 32'(dut.stage), 32'(S1));
        chk("abort_pc", dut.pc, 32'h0);
        chk("abort_x4", dut.regs[4], 32'h0);

        tick(4);
        chk("addi_pc", dut.pc, 32'h1);
        chk("addi_x4", dut.regs[4], 32'h55);
        tick(5);
        chk("gpio_pc", dut.pc, 32'h2);
        chk("gpio_val", 32'(gpio), 32'h55);
        chk("gpio_ram_kept", ram_word0(), 32'h0001F000);

        tick(4);
        chk("s4_stage", 32'(dut.stage), 32'(S4));
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("s4abort_stage", 32'(dut.stage), 32'(S1));
        chk("s4abort_ram", ram_word0(), 32'h0001F000);
        chk("s4abort_gpio", 32'(gpio), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_core.md
Name: riscv_core

Overview:
- Minimal multi-cycle RV32I subset CPU; each instruction takes exactly 5 clocks through a one-hot stage register.
- Contains the program ROM, byte-addressed data RAM, register file and an 8-bit GPIO output register.
- Top-level processor block of the FPGA sandbox; the bench peeks internal state hierarchically.

Parameters:
- PROG_WORDS, 1024, program memory depth in 32-bit words.
- DATA_BYTES, 1024, data memory depth in bytes.
- GPIO_ADDR, 32'h400, byte address of the GPIO register (outside RAM).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  reset; synchronous, active-high.
- gpio  output  8  GPIO output register.

Behaviour:
- Internal names are fixed for hierarchical test access:
  - stage[4:0], pc[31:0], opcode[6:0], regs[0:31] (32x32);
  - instance prog with array mem[0:PROG_WORDS-1] (32-bit);
  - instance memory with array mem[0:DATA_BYTES-1] (8-bit).
- Power-up: stage=5'b00001, pc=0, opcode=0, all regs=0, gpio=0, data RAM=0.
- Reset: same values for stage, pc, opcode, regs and gpio. Memories are not cleared.
- pc is a word index: instruction fetched = prog.mem[pc[9:0]]; sequential next pc = pc+1.
- Stages, one-hot, rotating 00001→00010→00100→01000→10000→00001 every clock with no stalls:
  - S1 fetch: latch instruction; opcode = instr[6:0]. Opcode is valid from S2 until the next S1 edge.
  - S2 decode: read rs1/rs2, form immediates.
  - S3 execute: compute result, address and next pc.
  - S4 memory: on the edge leaving S4, commit the store, the rd write (including load data) and the new pc.
  - S5 retire: idle; committed state is visible.
- regs[0] is never written and reads 0.
- Data RAM is big-endian. A word at byte address a is {mem[a],mem[a+1],mem[a+2],mem[a+3]}; word accesses ignore addr[1:0] (aligned).
- Supported instructions (unlisted opcodes, including all-zero, are NOPs: pc+1, no writes):
  - LUI 0110111: rd = {imm[31:12],12'h0}.
  - AUIPC 0010111: rd = (pc<<2) + U-imm.
  - JAL 1101111: rd = (pc+1)<<2; pc = pc + (J-imm>>>2).
  - JALR 1100111: rd = (pc+1)<<2; pc = ((rs1+I-imm)&~1)>>2. The target is computed from the old rs1 even when rd==rs1.
  - LOAD 0000011 funct3=010 (LW): rd = word at rs1+I-imm.
  - STORE 0100011 funct3=010 (SW): word at rs1+S-imm = rs2.
  - OP-IMM 0010011 funct3=000 (ADDI): rd = rs1+I-imm.
- Addresses are 32-bit and wrap modulo 2^32; the RAM index uses low bits modulo DATA_BYTES.
- SW to GPIO_ADDR writes gpio = rs2[7:0] and leaves RAM untouched. LW from GPIO_ADDR returns {24'h0,gpio}.
- Reset asserted mid-instruction aborts it: no commit occurs and the next edge starts S1 at pc=0.

Optional Feature:
- Macro RISCV_ALU_EN.
- Defined: full OP-IMM (ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI) and OP 0110011 (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND) per RV32I.
- Undefined: only ADDI is executed; all other OP-IMM and OP encodings are NOPs.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants LUI, AUIPC, JAL, JALR, LOAD, STORE, OP_IMM, OP;
  - funct3 constants LW, SW;
  - stage one-hot constants.
- Sub-module riscv_mem: generic synchronous-write array with parameters width and depth. It is instantiated twice, as prog (32-bit, PROG_WORDS) and memory (8-bit, DATA_BYTES).

Test Plan:
- Power-up/reset: before the first edge, stage=00001 and pc=0. After 1 clock, stage=00010 and opcode=LUI. Pulse reset in S3: the next cycle shows stage=00001, pc=0, no commit.
- Program {lui x1,0x1f; lui x2,0xf1}: after 4 clocks, stage=10000, pc=1, x1=0x0001F000. After 5 more clocks, pc=2, x2=0x000F1000.
- sw x1,0(x0) then lw x3,0(x0):
  - at pc=3 stage 5: mem[0..3]={00,01,F0,00};
  - x3 is 0 before the load;
  - at pc=4 stage 5: x3=0x0001F000.
- Zero words at pc 4..30: each retires as a NOP in 5 clocks. At pc=31 stage 5, opcode=0.
- jalr x0,0(x0) at word 31: 5 clocks later pc=0, opcode=JALR, x0 still 0. jalr x5,8(x0): pc=2, x5=128.
- addi x4,x0,0x55; sw x4,0x400(x0): gpio=8'h55, RAM bytes 0..3 unchanged.
